// File: rtl/rs_multi.sv
// rs_multi: age-ordered reservation station with multi-port CDB wakeup.
// Optional macro RS_WAKEUP_BYPASS_EN: same-cycle CDB matches count as ready.
module rs_multi #(
  parameter int RS_DEPTH  = 8,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 64,
  parameter int CDB_N     = 2,
  parameter int FU_N      = 3,
  parameter int FU_W      = (FU_N > 1) ? $clog2(FU_N) : 1,
  parameter int IDX_W     = $clog2(RS_DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [FU_W-1:0]           disp_fu,
  input  logic                      disp_t1_valid,
  input  logic                      disp_t2_valid,
  input  logic [PREG_W-1:0]         disp_t1_tag,
  input  logic [PREG_W-1:0]         disp_t2_tag,
  input  logic                      disp_t1_ready,
  input  logic                      disp_t2_ready,
  input  logic [PAYLOAD_W-1:0]      disp_payload,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*PREG_W-1:0]   cdb_tag,
  output logic [FU_N-1:0]           iss_valid,
  input  logic [FU_N-1:0]           iss_ready,
  output logic [FU_N*PAYLOAD_W-1:0] iss_payload,
  output logic [FU_N*IDX_W-1:0]     iss_idx,
  output logic [IDX_W:0]            occupancy
);

  typedef struct packed {
    logic                 busy;
    logic [FU_W-1:0]      fu;
    logic                 t1v;
    logic [PREG_W-1:0]    t1tag;
    logic                 t1r;
    logic                 t2v;
    logic [PREG_W-1:0]    t2tag;
    logic                 t2r;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t [RS_DEPTH-1:0] ent_q, ent_d;
  // older_q[i] has bit j set when entry j was dispatched before entry i
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;

  logic [RS_DEPTH-1:0] w1, w2;
  logic d1, d2;
  logic [FU_N-1:0][RS_DEPTH-1:0] elig, sel;
  logic [IDX_W-1:0] free_idx;
  logic free_found;

  // CDB tag matches for stored sources and for the dispatching sources
  always_comb begin
    w1 = '0;
    w2 = '0;
    d1 = 1'b0;
    d2 = 1'b0;
    for (int k = 0; k < CDB_N; k++) begin
      if (cdb_valid[k]) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (cdb_tag[k*PREG_W +: PREG_W] == ent_q[i].t1tag) w1[i] = 1'b1;
          if (cdb_tag[k*PREG_W +: PREG_W] == ent_q[i].t2tag) w2[i] = 1'b1;
        end
        if (cdb_tag[k*PREG_W +: PREG_W] == disp_t1_tag) d1 = 1'b1;
        if (cdb_tag[k*PREG_W +: PREG_W] == disp_t2_tag) d2 = 1'b1;
      end
    end
  end

  // Eligibility per class and oldest-first selection
  always_comb begin
    elig = '0;
    sel = '0;
    iss_valid = '0;
    iss_payload = '0;
    iss_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      logic r1, r2;
`ifdef RS_WAKEUP_BYPASS_EN
      r1 = !ent_q[i].t1v || ent_q[i].t1r || w1[i];
      r2 = !ent_q[i].t2v || ent_q[i].t2r || w2[i];
`else
      r1 = !ent_q[i].t1v || ent_q[i].t1r;
      r2 = !ent_q[i].t2v || ent_q[i].t2r;
`endif
      for (int f = 0; f < FU_N; f++)
        elig[f][i] = ent_q[i].busy && r1 && r2
                     && (ent_q[i].fu == FU_W'(f));
    end
    for (int f = 0; f < FU_N; f++) begin
      iss_valid[f] = |elig[f];
      for (int i = 0; i < RS_DEPTH; i++) begin
        sel[f][i] = elig[f][i] && !(|(elig[f] & older_q[i]));
        if (sel[f][i]) begin
          iss_payload[f*PAYLOAD_W +: PAYLOAD_W] = ent_q[i].payload;
          iss_idx[f*IDX_W +: IDX_W] = IDX_W'(i);
        end
      end
    end
  end

  // Occupancy, dispatch readiness and lowest free slot from registered state
  always_comb begin
    occupancy = '0;
    free_idx = '0;
    free_found = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      occupancy = occupancy + (IDX_W+1)'(ent_q[i].busy);
      if (!ent_q[i].busy && !free_found) begin
        free_idx = IDX_W'(i);
        free_found = 1'b1;
      end
    end
    disp_ready = (occupancy != (IDX_W+1)'(RS_DEPTH));
  end

  // Next state: issue-free, wakeup and dispatch together; flush overrides
  always_comb begin
    ent_d = ent_q;
    older_d = older_q;
    for (int f = 0; f < FU_N; f++)
      if (iss_valid[f] && iss_ready[f])
        for (int i = 0; i < RS_DEPTH; i++)
          if (sel[f][i]) ent_d[i].busy = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ent_q[i].busy && ent_q[i].t1v && w1[i]) ent_d[i].t1r = 1'b1;
      if (ent_q[i].busy && ent_q[i].t2v && w2[i]) ent_d[i].t2r = 1'b1;
    end
    if (disp_valid && disp_ready) begin
      ent_d[free_idx].busy    = 1'b1;
      ent_d[free_idx].fu      = disp_fu;
      ent_d[free_idx].t1v     = disp_t1_valid;
      ent_d[free_idx].t1tag   = disp_t1_tag;
      ent_d[free_idx].t1r     = disp_t1_ready || d1;
      ent_d[free_idx].t2v     = disp_t2_valid;
      ent_d[free_idx].t2tag   = disp_t2_tag;
      ent_d[free_idx].t2r     = disp_t2_ready || d2;
      ent_d[free_idx].payload = disp_payload;
      for (int i = 0; i < RS_DEPTH; i++) begin
        older_d[i][free_idx] = 1'b0;
        older_d[free_idx][i] = ent_q[i].busy;
      end
      older_d[free_idx][free_idx] = 1'b0;
    end
    if (flush)
      for (int i = 0; i < RS_DEPTH; i++) ent_d[i].busy = 1'b0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q   <= '0;
      older_q <= '0;
    end else begin
      ent_q   <= ent_d;
      older_q <= older_d;
    end
  end

endmodule
